// File: rtl/nivel2_timer.sv
// nivel2_timer
// Countdown cook timer feeding the level-2 magnetron controller.
// A four-digit MM:SS value is keyed in while the magnetron is off. The value
// counts down once per second while the controller enables it.
//
// Parameters:
//   CLK_HZ - clk cycles per counted second (>= 2)
//   PW     - prescaler width, 2**PW >= CLK_HZ
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   clearn     in   synchronous active-low clear
//   enable     in   count enable (controller Q)
//   key_valid  in   one-cycle strobe, key_digit holds a new digit
//   key_digit  in   entered digit, binary 0-9 (10-15 ignored)
//   min_tens   out  BCD minutes tens
//   min_ones   out  BCD minutes ones
//   sec_tens   out  BCD seconds tens
//   sec_ones   out  BCD seconds ones
//   timer_done out  high while the time is 00:00
//   tick       out  one-cycle pulse after each decrement edge
module nivel2_timer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int PW     = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       tick
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PRESC_ONE  = {{(PW-1){1'b0}}, 1'b1};

    // Time is held as {min_tens, min_ones, sec_tens, sec_ones}.
    logic [15:0]   time_r;
    logic [15:0]   time_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_s;
    logic          tick_r;
    logic          tick_s;
    logic          done_r;
    logic          done_s;
    logic          zero_s;
    logic          key_ok_s;

    // One-second decrement with the borrow chain starting at sec_ones.
    // Seconds tens wraps to 5, the other digits to 9. The caller never
    // decrements 00:00, so min_tens cannot underflow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        mt = t[15:12];
        mo = t[11:8];
        st = t[7:4];
        so = t[3:0];
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign zero_s   = (time_r == 16'h0000);
    assign key_ok_s = key_valid && !enable && (key_digit <= 4'd9);

    // Next-state: clear beats counting, counting beats key entry.
    always_comb begin
        time_s  = time_r;
        presc_s = zero_s ? PRESC_ZERO : presc_r;
        tick_s  = 1'b0;
        if (!clearn) begin
            time_s  = 16'h0000;
            presc_s = PRESC_ZERO;
        end else if (enable) begin
            // Keys pressed while enabled are dropped, not queued.
            if (zero_s) begin
                presc_s = PRESC_ZERO;
            end else if (presc_r == PRESC_LAST) begin
                presc_s = PRESC_ZERO;
                time_s  = bcd_dec(time_r);
                tick_s  = 1'b1;
            end else begin
                presc_s = presc_r + PRESC_ONE;
            end
        end else if (key_ok_s) begin
            // Shift left; the old min_tens falls off. The partial second
            // is kept, as for any pause.
            time_s = {time_r[11:0], key_digit};
        end else begin
            time_s = time_r;
        end
        // Done follows the next-state digits, so it moves with them.
        done_s = (time_s == 16'h0000);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_r  <= 16'h0000;
            presc_r <= PRESC_ZERO;
            tick_r  <= 1'b0;
            done_r  <= 1'b1;
        end else begin
            time_r  <= time_s;
            presc_r <= presc_s;
            tick_r  <= tick_s;
            done_r  <= done_s;
        end
    end

    assign min_tens   = time_r[15:12];
    assign min_ones   = time_r[11:8];
    assign sec_tens   = time_r[7:4];
    assign sec_ones   = time_r[3:0];
    assign timer_done = done_r;
    assign tick       = tick_r;

endmodule

// File: tb/tb_nivel2_timer.sv
module tb_nivel2_timer;

    localparam int CLK_HZ = 4;
    localparam int PW     = 3;

    logic       clk;
    logic       rst;
    logic       clearn;
    logic       enable;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;
    logic       tick;

    nivel2_timer #(.CLK_HZ(CLK_HZ), .PW(PW)) dut (
        .clk(clk), .rst(rst), .clearn(clearn), .enable(enable),
        .key_valid(key_valid), .key_digit(key_digit),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .timer_done(timer_done), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected {min_tens,min_ones,sec_tens,sec_ones,timer_done,tick} per edge.
    logic [17:0] exp_q[$];

    // Reference model: digits m[0]=min tens .. m[3]=sec ones, sub-second count p.
    int m[4];
    int p;

    function automatic bit model_zero();
        return (m[0] == 0) && (m[1] == 0) && (m[2] == 0) && (m[3] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 0;
        p = 0;
    endtask

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the state after the next edge.
    task automatic step(input logic en, input logic kv, input logic [3:0] kd, input logic cl);
        bit z;
        bit tk;
        logic [17:0] e;
        @(negedge clk);
        enable = en; key_valid = kv; key_digit = kd; clearn = cl;
        z  = model_zero();
        tk = 1'b0;
        if (!cl) begin
            model_reset();
        end else if (en) begin
            if (z) begin
                p = 0;
            end else if (p == CLK_HZ - 1) begin
                p  = 0;
                tk = 1'b1;
                if (m[3] > 0) m[3]--;
                else begin
                    m[3] = 9;
                    if (m[2] > 0) m[2]--;
                    else begin
                        m[2] = 5;
                        if (m[1] > 0) m[1]--;
                        else begin
                            m[1] = 9;
                            m[0]--;
                        end
                    end
                end
            end else begin
                p++;
            end
        end else if (kv && kd <= 4'd9) begin
            m[0] = m[1]; m[1] = m[2]; m[2] = m[3]; m[3] = int'(kd);
        end
        e = {4'(m[0]), 4'(m[1]), 4'(m[2]), 4'(m[3]), model_zero(), tk};
        exp_q.push_back(e);
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        step(1'b0, 1'b1, 4'(a), 1'b1);
        step(1'b0, 1'b1, 4'(b), 1'b1);
        step(1'b0, 1'b1, 4'(c), 1'b1);
        step(1'b0, 1'b1, 4'(d), 1'b1);
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 4'd0, 1'b1);
    endtask

    // Async reset between edges; outputs must settle before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        enable = 1'b0; key_valid = 1'b0; clearn = 1'b1;
        #1 rst = 1'b1;
        #1 chk("async_reset", {min_tens, min_ones, sec_tens, sec_ones, timer_done, tick},
               {16'h0000, 1'b1, 1'b0});
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Monitor: after every edge compare DUT outputs to the oldest prediction.
    always @(posedge clk) begin
        logic [17:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("edge", {min_tens, min_ones, sec_tens, sec_ones, timer_done, tick}, e);
        end
    end

    initial begin
        rst = 1'b1; clearn = 1'b1; enable = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        model_reset();
        #3 chk("reset_hold", {min_tens, min_ones, sec_tens, sec_ones, timer_done, tick},
               {16'h0000, 1'b1, 1'b0});
        #9 rst = 1'b0;

        // Entry: 1,3,0 then an illegal 12.
        load(0, 1, 3, 0);
        step(1'b0, 1'b1, 4'd12, 1'b1);
        // Count with borrow: 01:30 for 8 edges.
        run(8, 1'b1);
        async_reset();
        load(0, 1, 0, 0);
        run(4, 1'b1);
        // Pause keeps partial second; key during enable ignored.
        load(0, 0, 1, 0);
        run(2, 1'b1);
        run(5, 1'b0);
        step(1'b1, 1'b1, 4'd7, 1'b1);
        run(2, 1'b1);
        // Done and idle at 00:00.
        load(0, 0, 0, 2);
        run(12, 1'b1);
        load(0, 0, 0, 1);
        run(4, 1'b1);
        // Clear wins over a wrap edge.
        load(0, 5, 0, 0);
        run(3, 1'b1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        load(0, 0, 7, 5);
        run(4, 1'b1);
        // Zeros-only entry keeps done high.
        load(0, 0, 0, 0);

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            if ((i % 60) < 8)
                step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
            else
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 50) != 0));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
